// File: rtl/arm_soc_pkg.sv
// Shared constants and types for the ARM SoC data-side subsystem:
// IO register offsets, TIMER_CTRL bit positions and the address-region enum.
package arm_soc_pkg;

  localparam logic [4:0] GPIO_OUT_OFS    = 5'h00;
  localparam logic [4:0] GPIO_IN_OFS     = 5'h04;
  localparam logic [4:0] TIMER_COUNT_OFS = 5'h08;
  localparam logic [4:0] TIMER_CMP_OFS   = 5'h0C;
  localparam logic [4:0] TIMER_CTRL_OFS  = 5'h10;
  localparam logic [4:0] STATUS_OFS      = 5'h14;

  localparam int unsigned CTRL_EN_BIT    = 32'd0;
  localparam int unsigned CTRL_CLR_BIT   = 32'd1;
  localparam int unsigned CTRL_IRQEN_BIT = 32'd2;
  localparam int unsigned CTRL_PRESC_LSB = 32'd8;
  localparam int unsigned CTRL_PRESC_MSB = 32'd15;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_IO   = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  // Little-endian byte lane select, zero-extended to a full word.
  function automatic logic [31:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return {24'h00_0000, word[7:0]};
      2'd1:    return {24'h00_0000, word[15:8]};
      2'd2:    return {24'h00_0000, word[23:16]};
      2'd3:    return {24'h00_0000, word[31:24]};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/arm_soc_timer.sv
// Prescaled timer with compare flag and interrupt (COUNT, CMP, CTRL, STATUS).
// Present only when ARM_SOC_TIMER_EN is defined; otherwise reads 0 and never interrupts.
module arm_soc_timer
  import arm_soc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [4:0]  ofs_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

`ifdef ARM_SOC_TIMER_EN
  localparam logic [31:0] CtrlMask = 32'h0000_FF07;

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [7:0]  presc_q, presc_d;
  logic        flag_q, flag_d;
  logic        enable_s, tick_s, match_s;
  logic        count_wr_s, cmp_wr_s, ctrl_wr_s, status_wr_s;

  assign enable_s    = ctrl_q[CTRL_EN_BIT];
  assign tick_s      = enable_s && (presc_q == ctrl_q[CTRL_PRESC_MSB:CTRL_PRESC_LSB]);
  assign count_wr_s  = wr_en_i && (ofs_i == TIMER_COUNT_OFS);
  assign cmp_wr_s    = wr_en_i && (ofs_i == TIMER_CMP_OFS);
  assign ctrl_wr_s   = wr_en_i && (ofs_i == TIMER_CTRL_OFS);
  assign status_wr_s = wr_en_i && (ofs_i == STATUS_OFS);

  // Next-state: software COUNT writes beat ticks, hardware flag set beats software clear.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    flag_d  = flag_q;
    match_s = 1'b0;

    if (ctrl_wr_s && wdata_i[CTRL_EN_BIT] && !enable_s) begin
      presc_d = 8'd0;
    end else if (tick_s) begin
      presc_d = 8'd0;
    end else if (enable_s) begin
      presc_d = presc_q + 8'd1;
    end else begin
      presc_d = presc_q;
    end

    if (count_wr_s) begin
      count_d = wdata_i;
    end else if (tick_s) begin
      match_s = (count_q == cmp_q);
      if (match_s && ctrl_q[CTRL_CLR_BIT]) begin
        count_d = 32'h0000_0000;
      end else begin
        count_d = count_q + 32'd1;
      end
    end else begin
      count_d = count_q;
    end

    cmp_d  = cmp_wr_s  ? wdata_i : cmp_q;
    ctrl_d = ctrl_wr_s ? (wdata_i & CtrlMask) : ctrl_q;

    if (match_s) begin
      flag_d = 1'b1;
    end else if (status_wr_s && wdata_i[0]) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 8'd0;
      count_q <= 32'h0000_0000;
      cmp_q   <= 32'h0000_0000;
      ctrl_q  <= 32'h0000_0000;
      flag_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
    end
  end

  // Register read-back.
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (ofs_i)
      TIMER_COUNT_OFS: rdata_o = count_q;
      TIMER_CMP_OFS:   rdata_o = cmp_q;
      TIMER_CTRL_OFS:  rdata_o = ctrl_q;
      STATUS_OFS:      rdata_o = {31'h0000_0000, flag_q};
      default:         rdata_o = 32'h0000_0000;
    endcase
  end

  assign irq_o = flag_q & ctrl_q[CTRL_IRQEN_BIT];
`else
  logic unused_s;
  assign unused_s = ^{clk_i, rst_ni, wr_en_i, ofs_i, wdata_i};
  assign rdata_o  = 32'h0000_0000;
  assign irq_o    = 1'b0;
`endif

endmodule

// File: rtl/arm_soc_data_subsystem.sv
// Data-side memory subsystem: address decoder, byte-capable word RAM, GPIO and timer.
// The timer registers and o_IRQ are only live when ARM_SOC_TIMER_EN is defined.
module arm_soc_data_subsystem
  import arm_soc_pkg::*;
#(
  parameter int          BusWidth = 32,
  parameter int          RamDepth = 64,
  parameter int          NumGpio  = 8,
  parameter logic [31:0] IoBase   = 32'h8000_0000
) (
  input  logic                i_CLK,
  input  logic                i_RESET_N,
  input  logic [BusWidth-1:0] i_Address,
  input  logic [BusWidth-1:0] i_Write_Data,
  input  logic                i_Mem_Write,
  input  logic                i_Byte_Access,
  output logic [BusWidth-1:0] o_Read_Data,
  input  logic [NumGpio-1:0]  i_GPIO_In,
  output logic [NumGpio-1:0]  o_GPIO_Out,
  output logic                o_IRQ
);

  localparam int          AddrBits = $clog2(RamDepth);
  localparam logic [31:0] RamBytes = 32'(RamDepth * 4);
  localparam logic [31:0] IoLast   = IoBase + 32'h0000_0017;

  region_e              region_s;
  logic [4:0]           io_ofs_s;
  logic [4:0]           reg_ofs_s;
  logic [1:0]           lane_s;
  logic [AddrBits-1:0]  ram_idx_s;
  logic                 io_wr_s;
  logic [31:0]          word_s;
  logic [31:0]          tmr_rdata_s;
  logic [31:0]          mem_q [RamDepth];
  logic [NumGpio-1:0]   gpio_out_q, gpio_out_d;
  logic [NumGpio-1:0]   sync1_q, sync2_q;

  // Address decode into RAM / IO / unmapped.
  always_comb begin
    region_s = REGION_NONE;
    if (i_Address < RamBytes) begin
      region_s = REGION_RAM;
    end else if ((i_Address >= IoBase) && (i_Address <= IoLast)) begin
      region_s = REGION_IO;
    end else begin
      region_s = REGION_NONE;
    end
  end

  assign io_ofs_s  = i_Address[4:0] - IoBase[4:0];
  assign reg_ofs_s = {io_ofs_s[4:2], 2'b00};
  assign lane_s    = (region_s == REGION_IO) ? io_ofs_s[1:0] : i_Address[1:0];
  assign ram_idx_s = i_Address[AddrBits+1:2];
  assign io_wr_s   = i_Mem_Write && !i_Byte_Access && (region_s == REGION_IO);

  // RAM store port; contents are deliberately not reset.
  always_ff @(posedge i_CLK) begin
    if (i_Mem_Write && (region_s == REGION_RAM)) begin
      if (i_Byte_Access) begin
        mem_q[ram_idx_s][{lane_s, 3'b000} +: 8] <= i_Write_Data[7:0];
      end else begin
        mem_q[ram_idx_s] <= i_Write_Data;
      end
    end
  end

  assign gpio_out_d = (io_wr_s && (reg_ofs_s == GPIO_OUT_OFS)) ? i_Write_Data[NumGpio-1:0]
                                                               : gpio_out_q;

  // GPIO output register and two-flop input synchroniser.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= i_GPIO_In;
      sync2_q    <= sync1_q;
    end
  end

  arm_soc_timer u_timer (
    .clk_i   (i_CLK),
    .rst_ni  (i_RESET_N),
    .wr_en_i (io_wr_s),
    .ofs_i   (reg_ofs_s),
    .wdata_i (i_Write_Data),
    .rdata_o (tmr_rdata_s),
    .irq_o   (o_IRQ)
  );

  // Combinational load mux so a single-cycle load completes in the same cycle.
  always_comb begin
    word_s = 32'h0000_0000;
    case (region_s)
      REGION_RAM: word_s = mem_q[ram_idx_s];
      REGION_IO: begin
        case (reg_ofs_s)
          GPIO_OUT_OFS: word_s = 32'(gpio_out_q);
          GPIO_IN_OFS:  word_s = 32'(sync2_q);
          default:      word_s = tmr_rdata_s;
        endcase
      end
      default:    word_s = 32'h0000_0000;
    endcase
    o_Read_Data = i_Byte_Access ? byte_lane(word_s, lane_s) : word_s;
  end

  assign o_GPIO_Out = gpio_out_q;

endmodule

// File: tb/tb_arm_soc_data_subsystem.sv
// Directed self-checking bench for arm_soc_data_subsystem; timer scenarios follow ARM_SOC_TIMER_EN.
module tb_arm_soc_data_subsystem;

  localparam logic [31:0] IO = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_Address = 32'h0;
  logic [31:0] i_Write_Data = 32'h0;
  logic        i_Mem_Write = 1'b0;
  logic        i_Byte_Access = 1'b0;
  logic [31:0] o_Read_Data;
  logic [7:0]  i_GPIO_In = 8'h00;
  logic [7:0]  o_GPIO_Out;
  logic        o_IRQ;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  arm_soc_data_subsystem dut (
    .i_CLK         (clk),
    .i_RESET_N     (rst_n),
    .i_Address     (i_Address),
    .i_Write_Data  (i_Write_Data),
    .i_Mem_Write   (i_Mem_Write),
    .i_Byte_Access (i_Byte_Access),
    .o_Read_Data   (o_Read_Data),
    .i_GPIO_In     (i_GPIO_In),
    .o_GPIO_Out    (o_GPIO_Out),
    .o_IRQ         (o_IRQ)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic b);
    i_Address = a; i_Write_Data = d; i_Byte_Access = b; i_Mem_Write = 1'b1;
    @(posedge clk); #1;
    i_Mem_Write = 1'b0; i_Byte_Access = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic b, output logic [31:0] d);
    i_Address = a; i_Byte_Access = b;
    #1;
    d = o_Read_Data;
    i_Byte_Access = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_GPIO_Out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out: got %h want 00", o_GPIO_Out); end
    checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", o_IRQ); end
    bus_read(IO + 32'h00, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_gpio_reg: got %h want 0", rd); end
    bus_read(IO + 32'h14, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte_ram;
    bus_write(32'h10, 32'h1122_3344, 1'b0);
    bus_write(32'h12, 32'h0000_00AA, 1'b1);
    bus_read(32'h10, 1'b0, rd);
    checks++; if (rd !== 32'h11AA_3344) begin errors++; $display("FAIL ram_strb_word: got %h want 11aa3344", rd); end
    bus_read(32'h13, 1'b1, rd);
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL ram_ldrb3: got %h want 00000011", rd); end
    bus_read(32'h10, 1'b1, rd);
    checks++; if (rd !== 32'h0000_0044) begin errors++; $display("FAIL ram_ldrb0: got %h want 00000044", rd); end
    bus_read(32'h11, 1'b0, rd);
    checks++; if (rd !== 32'h11AA_3344) begin errors++; $display("FAIL ram_word_unaligned: got %h want 11aa3344", rd); end
    bus_write(32'h00, 32'h1234_5678, 1'b0);
    bus_write(32'hFC, 32'hCAFE_F00D, 1'b0);
    bus_write(32'h100, 32'hDEAD_BEEF, 1'b0);
    bus_read(32'hFC, 1'b0, rd);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_last_word: got %h want cafef00d", rd); end
    bus_read(32'h00, 1'b0, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_no_alias: got %h want 12345678", rd); end
  endtask

  task automatic test_unmapped;
    bus_read(32'h4000_0000, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", rd); end
    bus_read(32'h100, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ram_end_read: got %h want 0", rd); end
    bus_read(IO + 32'h18, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL io_end_read: got %h want 0", rd); end
    bus_write(32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
    bus_read(32'h00, 1'b0, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL unmapped_write: got %h want 12345678", rd); end
  endtask

  task automatic test_gpio;
    bus_write(IO + 32'h00, 32'h0000_005A, 1'b0);
    checks++; if (o_GPIO_Out !== 8'h5A) begin errors++; $display("FAIL gpio_out: got %h want 5a", o_GPIO_Out); end
    bus_write(IO + 32'h00, 32'h0000_00FF, 1'b1);
    checks++; if (o_GPIO_Out !== 8'h5A) begin errors++; $display("FAIL gpio_strb_ignored: got %h want 5a", o_GPIO_Out); end
    bus_read(IO + 32'h00, 1'b1, rd);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL gpio_ldrb0: got %h want 5a", rd); end
    bus_read(IO + 32'h01, 1'b1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL gpio_ldrb1: got %h want 0", rd); end
    i_GPIO_In = 8'h3C;
    @(posedge clk); #1;
    bus_read(IO + 32'h04, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL gpio_in_edge1: got %h want 0", rd); end
    @(posedge clk); #1;
    bus_read(IO + 32'h04, 1'b0, rd);
    checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL gpio_in_edge2: got %h want 3c", rd); end
  endtask

`ifdef ARM_SOC_TIMER_EN
  task automatic test_timer_autoclear;
    bus_write(IO + 32'h08, 32'h0, 1'b0);
    bus_write(IO + 32'h0C, 32'h3, 1'b0);
    bus_write(IO + 32'h10, 32'h0000_0107, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e < 8) begin
        checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL irq_early edge %0d: got %b want 0", e, o_IRQ); end
      end else begin
        checks++; if (o_IRQ !== 1'b1) begin errors++; $display("FAIL irq_edge8: got %b want 1", o_IRQ); end
      end
    end
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL count_cleared: got %h want 0", rd); end
    bus_write(IO + 32'h14, 32'h1, 1'b0);
    checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL irq_status_clear: got %b want 0", o_IRQ); end
    bus_write(IO + 32'h10, 32'h0, 1'b0);
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_write_old_tick: got %h want 1", rd); end
    repeat (4) @(posedge clk);
    #1;
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL count_frozen: got %h want 1", rd); end
  endtask

  task automatic test_collisions;
    bus_write(IO + 32'h10, 32'h0000_0001, 1'b0);
    bus_write(IO + 32'h08, 32'h0000_0100, 1'b0);
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h0000_0100) begin errors++; $display("FAIL count_write_wins: got %h want 100", rd); end
    bus_write(IO + 32'h10, 32'h0, 1'b0);
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h0000_0101) begin errors++; $display("FAIL count_after_tick: got %h want 101", rd); end
    bus_write(IO + 32'h0C, 32'h0000_0102, 1'b0);
    bus_write(IO + 32'h10, 32'h0000_0005, 1'b0);
    @(posedge clk); #1;
    bus_write(IO + 32'h14, 32'h1, 1'b0);
    checks++; if (o_IRQ !== 1'b1) begin errors++; $display("FAIL flag_set_wins: got %b want 1", o_IRQ); end
    bus_write(IO + 32'h10, 32'h0, 1'b0);
    checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL irq_en_gate: got %b want 0", o_IRQ); end
    bus_read(IO + 32'h14, 1'b0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL status_held: got %h want 1", rd); end
    bus_write(IO + 32'h14, 32'h0, 1'b0);
    bus_read(IO + 32'h14, 1'b0, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL status_write0: got %h want 1", rd); end
    bus_write(IO + 32'h14, 32'h1, 1'b0);
    bus_read(IO + 32'h14, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_write1: got %h want 0", rd); end
  endtask
`else
  task automatic test_timer_disabled;
    bus_write(IO + 32'h08, 32'h0000_FFFF, 1'b0);
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cfg_count_read: got %h want 0", rd); end
    bus_write(IO + 32'h0C, 32'h0, 1'b0);
    bus_write(IO + 32'h10, 32'h0000_0105, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL cfg_irq: got %b want 0", o_IRQ); end
    bus_read(IO + 32'h10, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cfg_ctrl_read: got %h want 0", rd); end
    bus_read(IO + 32'h14, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cfg_status_read: got %h want 0", rd); end
  endtask
`endif

  task automatic test_async_reset;
    bus_write(IO + 32'h00, 32'h0000_00A5, 1'b0);
    checks++; if (o_GPIO_Out !== 8'hA5) begin errors++; $display("FAIL pre_reset_gpio: got %h want a5", o_GPIO_Out); end
`ifdef ARM_SOC_TIMER_EN
    bus_write(IO + 32'h08, 32'h0, 1'b0);
    bus_write(IO + 32'h0C, 32'h0, 1'b0);
    bus_write(IO + 32'h10, 32'h0000_0005, 1'b0);
    @(posedge clk); #1;
    checks++; if (o_IRQ !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", o_IRQ); end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_GPIO_Out !== 8'h00) begin errors++; $display("FAIL async_reset_gpio: got %h want 00", o_GPIO_Out); end
    checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b want 0", o_IRQ); end
    bus_read(IO + 32'h08, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL async_reset_count: got %h want 0", rd); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_IRQ !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b want 0", o_IRQ); end
    bus_read(IO + 32'h14, 1'b0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_status: got %h want 0", rd); end
  endtask

  initial begin
    test_reset;
    test_byte_ram;
    test_unmapped;
    test_gpio;
`ifdef ARM_SOC_TIMER_EN
    test_timer_autoclear;
    test_collisions;
`else
    test_timer_disabled;
`endif
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
